// File: rtl/packet_tx_arbiter.sv
// packet_tx_arbiter
//
// Packet-granular round-robin arbiter that shares one 64-bit transmit stream
// between CHANNELS packet sources. A channel, once granted, keeps the grant
// until its end-of-packet word has been popped, so packets never interleave.
//
// Optional feature macro: PACKET_TX_ARBITER_STATS_EN
//   Adds a per-channel completed-packet counter and the pkt_count port.
//
// Parameters
//   CHANNELS   number of sources, 2..8
//   CNT_WIDTH  width of each packet counter (stats build only)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   in_pop      per-source pop strobe
//   in_nempty   per-source word available
//   in_data     source words, channel k at [64k+63:64k]
//   in_end      per-source last-word-of-packet flag
//   out_pop     pop from the network block
//   out_nempty  a word is presented
//   out_data    presented word
//   out_end     presented word ends its packet
//   grant       index of the locked channel, valid while busy
//   busy        a packet is in progress
//   pkt_count   completed packets per channel (stats build only)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no packet in flight; arbitrate among requesters (bubble cycle)
// LOCKED | stream of channel 'grant' is passed through until its end word

module packet_tx_arbiter #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [CHANNELS-1:0]          in_pop,
    input  logic [CHANNELS-1:0]          in_nempty,
    input  logic [64*CHANNELS-1:0]       in_data,
    input  logic [CHANNELS-1:0]          in_end,
    input  logic                         out_pop,
    output logic                         out_nempty,
    output logic [63:0]                  out_data,
    output logic                         out_end,
    output logic [2:0]                   grant,
    output logic                         busy
`ifdef PACKET_TX_ARBITER_STATS_EN
    ,
    output logic [CNT_WIDTH*CHANNELS-1:0] pkt_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  last;

    // Channel vectors padded to 8 entries so a 3-bit grant can index them
    // for any CHANNELS value without range issues.
    logic [7:0]  nempty_pad;
    logic [7:0]  end_pad;
    logic [7:0]  pop_pad;
    logic [63:0] data_arr [8];

    logic        pick_valid;
    logic [2:0]  pick_idx;
    logic [3:0]  cand;
    logic        xfer;

    always_comb begin
        nempty_pad = '0;
        end_pad    = '0;
        for (int k = 0; k < 8; k++) begin
            data_arr[k] = '0;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            nempty_pad[k] = in_nempty[k];
            end_pad[k]    = in_end[k];
            data_arr[k]   = in_data[64*k +: 64];
        end
    end

    // Cyclic search starting at last+1. Walking the offsets from farthest to
    // nearest lets the nearest requester overwrite the result and win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            cand = {1'b0, last} + 4'(i);
            if (cand >= 4'(CHANNELS)) begin
                cand = cand - 4'(CHANNELS);
            end
            if (nempty_pad[cand[2:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    // Pass-through mux; no path from out_pop to out_nempty.
    assign out_nempty = (state == LOCKED) && nempty_pad[grant];
    assign out_data   = data_arr[grant];
    assign out_end    = end_pad[grant];
    assign xfer       = out_pop && out_nempty;

    always_comb begin
        pop_pad        = '0;
        pop_pad[grant] = xfer;
    end

    assign in_pop = pop_pad[CHANNELS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= 3'(CHANNELS - 1);
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        state <= LOCKED;
                        busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (xfer && out_end) begin
                        last  <= grant;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PACKET_TX_ARBITER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [CHANNELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (xfer && out_end && (grant == 3'(k))) begin
                    cnt[k] <= cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pkt_count[CNT_WIDTH*k +: CNT_WIDTH] = cnt[k];
        end
    end
`endif

endmodule

// File: doc/packet_tx_arbiter.md
# packet_tx_arbiter

Packet-granular round-robin arbiter that shares the single 64-bit network transmit stream (`net_ecp5` `tx_*` port) between `CHANNELS` packet sources, e.g. several `packet_device` instances or a CPU source plus a hardware streamer. It sits between the sources and the network block in the `clk` domain. Once a channel is granted, the arbiter holds that grant until the word flagged `end` has been popped, so packets are never interleaved.

## Interface
- `CHANNELS`, 2: number of requesting sources, 2..8.
- `CNT_WIDTH`, 16: width of each per-channel packet counter (present only with `PACKET_TX_ARBITER_STATS_EN`).

- `clk` input 1: system clock, 50 MHz in the radio top.
- `rst_n` input 1: reset, asynchronous assert, active-low. Deassert synchronously to `clk` externally.
- `in_pop` output CHANNELS: per-source pop strobe.
- `in_nempty` input CHANNELS: per-source word available.
- `in_data` input 64*CHANNELS: source words; channel k is bits [64k+63:64k].
- `in_end` input CHANNELS: the current word of channel k is the last word of its packet.
- `out_pop` input 1: pop from the network block.
- `out_nempty` output 1: a word is presented.
- `out_data` output 64: presented word.
- `out_end` output 1: the presented word is the last word of its packet.
- `grant` output 3: index of the locked channel. Valid while `busy`.
- `busy` output 1: a packet is in progress.
- `pkt_count` output CNT_WIDTH*CHANNELS: completed packets per channel. This port exists only with the stats macro.

## Operation
- Stream rule on both sides: a word transfers in a cycle where `pop && nempty`. `data` and `end` must be stable while `nempty` is high and the word is not popped.
- The FSM has two states, IDLE and LOCKED.
- IDLE:
  - `out_nempty=0` and `in_pop=0`.
  - If any `in_nempty` bit is set, select the first set channel, searching cyclically from `last+1`. Register it into `grant`, then go to LOCKED.
  - `last` resets to CHANNELS-1, so channel 0 wins first.
- LOCKED (g=`grant`):
  - `out_nempty=in_nempty[g]`, `out_data=in_data[g]`, `out_end=in_end[g]`. These are combinational.
  - `in_pop[g]=out_pop & in_nempty[g]`. All other `in_pop` bits are 0.
- Exit from LOCKED: a transfer with `out_end=1` sets `last<=g` and returns the FSM to IDLE in the next cycle.
- A source going empty mid-packet: the arbiter stays LOCKED with `out_nempty=0` for as long as needed. There is no timeout and no preemption.
- Requests that change while LOCKED are ignored until the FSM returns to IDLE.
- `out_pop` while `out_nempty=0` has no effect.
- `busy = (state==LOCKED)`.
- Reset values: state=IDLE, `grant=0`, `last=CHANNELS-1`, `busy=0`, `out_nempty=0`, `in_pop=0`, `pkt_count=0`. `out_data` and `out_end` are don't-care while `out_nempty=0`. Reset mid-packet abandons the packet; the source is not popped further.

## Timing
- Request to first presentable word: 1 cycle (the IDLE arbitration cycle). `out_nempty` rises in the cycle after IDLE sees `in_nempty`.
- Once locked, data path latency is 0 cycles (combinational mux), so the stream sustains 1 word/cycle within a packet.
- Between packets there is exactly 1 bubble cycle (the IDLE cycle), even when the same channel is the only requester.
- A single-word packet (`end` set on the first word) occupies 2 cycles per packet: IDLE plus 1 transfer.
- `grant` and `last` are registered. No combinational path runs from `out_pop` to `out_nempty`.

## Configuration
- `PACKET_TX_ARBITER_STATS_EN` defined:
  - Adds the `pkt_count` port and one CNT_WIDTH counter per channel.
  - The counter of channel g increments on each `out_end` transfer while g is granted.
  - Counters wrap modulo 2^CNT_WIDTH and reset to 0.
- Not defined: no counters and no `pkt_count` port. All other behaviour is identical.

## Test plan
- Reset with all sources full: hold `rst_n=0` -> `out_nempty=0` and `in_pop=0`. After release, grant=0 and `out_nempty` is high one cycle later.
- Channels 0 and 1 each queue a 3-word packet (data 0xA0..A2, 0xB0..B2), `out_pop` tied high -> output is A0,A1,A2,(bubble),B0,B1,B2 with `out_end` only on A2 and B2; `busy` low exactly during the bubble.
- Round-robin fairness, CHANNELS=4: all four sources continuously provide 1-word packets -> grant sequence 0,1,2,3,0,1. Each packet takes 2 cycles.
- Mid-packet stall: channel 1 presents word 0x11, goes empty for 5 cycles while channel 0 requests, then presents 0x12 with end -> `out_nempty=0` for 5 cycles, grant stays 1, and channel 0 is served only after 0x12.
- Backpressure: `out_pop` toggles 1,0,1,0 during a 4-word packet -> `in_pop` mirrors `out_pop`, no word is duplicated or dropped, and data is stable while not popped.
- With `PACKET_TX_ARBITER_STATS_EN` and CNT_WIDTH=4: send 17 packets on channel 2 -> `pkt_count[2]=1` after wrap and the other counters read 0. Assert `rst_n` low mid-packet -> all counters are 0.
